// File: rtl/xg_mem_pkg.sv
// Shared types and defaults for the SDRAM burst-port arbiter.
// Default widths, the arbiter state type and a one-hot decode helper.
package xg_mem_pkg;

  localparam int NUM_PORTS_DEF      = 3;
  localparam int ADDR_W_DEF         = 17;
  localparam int VID_MAX_CONSEC_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam logic [1:0] BURST_LAST_OFFSET = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BURST,
    ST_GAP
  } arb_state_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    onehot_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) onehot_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/xg_mem_arbiter_if.sv
// Requester-side bus of the burst-port arbiter: request capture, beat
// steering and completion, bundled per port as flat vectors.
interface xg_mem_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 17
);
  logic [NUM_PORTS-1:0]        port_req;
  logic [NUM_PORTS-1:0]        port_wren;
  logic [NUM_PORTS*ADDR_W-1:0] port_addr;
  logic [NUM_PORTS*16-1:0]     port_wdata;
  logic [NUM_PORTS-1:0]        port_ack;
  logic [NUM_PORTS-1:0]        port_ready;
  logic [1:0]                  port_offset;
  logic [NUM_PORTS-1:0]        port_done;
  logic [15:0]                 port_rdata;

  modport master (
    output port_req, port_wren, port_addr, port_wdata,
    input  port_ack, port_ready, port_offset, port_done, port_rdata
  );

  modport slave (
    input  port_req, port_wren, port_addr, port_wdata,
    output port_ack, port_ready, port_offset, port_done, port_rdata
  );
endinterface

// File: rtl/xg_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after
// ptr, scanning upward with wrap; returns a one-hot winner (0 if none).
module xg_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);

  always_comb begin : scan
    int   idx;
    logic found;
    // NOTE: every output of a combinational block gets a default first so no
    // path through the loops leaves it unassigned and infers a latch.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!found && (j == idx) && pending[j]) begin
          winner[j] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xg_mem_arbiter.sv
// Shares the SDRAM controller burst port between NUM_PORTS requesters:
// bounded priority for port 0, round-robin for the rest, burst watchdog.
module xg_mem_arbiter
  import xg_mem_pkg::*;
#(
  parameter int NUM_PORTS      = NUM_PORTS_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int VID_MAX_CONSEC = VID_MAX_CONSEC_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  xg_mem_arbiter_if.slave      req_bus,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 err_timeout,
  input  logic                 err_clr,
  output logic                 mem_req,
  output logic                 mem_wren,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [15:0]          to_mem,
  input  logic                 mem_ready,
  input  logic [1:0]           mem_offset,
  input  logic [15:0]          from_mem
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam int CW    = $clog2(VID_MAX_CONSEC + 1);

  arb_state_t             state;
  logic [NUM_PORTS-1:0]   pending, cap, pend_rr, rr_win, win_oh, release_oh;
  logic [NUM_PORTS-1:0]   ack_q, done_q, lat_wren;
  logic [ADDR_W-1:0]      lat_addr [NUM_PORTS];
  logic [15:0]            wdata    [NUM_PORTS];
  logic [PTR_W-1:0]       rr_ptr, win_idx, gidx;
  logic [CW-1:0]          consec;
  logic [7:0]             wd;
  logic                   others, vid_win, in_burst, burst_end, wd_expire;

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) wdata[k] = req_bus.port_wdata[k*16 +: 16];
  end

  assign cap     = req_bus.port_req & ~pending;
  assign pend_rr = pending & ~NUM_PORTS'(1);
  assign others  = |pend_rr;
  assign vid_win = pending[0] && !((consec == CW'(VID_MAX_CONSEC)) && others);

  xg_rr_pick #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_rr_pick (
    .pending (pend_rr),
    .ptr     (rr_ptr),
    .winner  (rr_win)
  );

  assign win_oh  = vid_win ? NUM_PORTS'(1) : rr_win;
  assign win_idx = PTR_W'(onehot_idx(8'(win_oh)));

  assign in_burst   = (state == ST_BURST);
  assign burst_end  = in_burst && mem_ready && (mem_offset == BURST_LAST_OFFSET);
  assign wd_expire  = in_burst && !burst_end && (wd == 8'(TIMEOUT_CYCLES - 1));
  assign release_oh = (burst_end || wd_expire) ? grant : '0;

  // Beat path is combinational so the winner sees each beat in its own cycle.
  assign req_bus.port_ready  = (in_burst && mem_ready) ? grant : '0;
  assign req_bus.port_offset = mem_offset;
  assign req_bus.port_rdata  = from_mem;
  assign req_bus.port_ack    = ack_q;
  assign req_bus.port_done   = done_q;
  assign to_mem              = in_burst ? wdata[gidx] : 16'd0;

  // NOTE: the captured address/direction table is plain datapath qualified by
  // pending, so it is deliberately left out of reset.
  always_ff @(posedge clk_sys) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (cap[k]) begin
        lat_wren[k] <= req_bus.port_wren[k];
        lat_addr[k] <= req_bus.port_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // A capture and a release of different ports on one edge both take effect.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      ack_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      pending <= (pending & ~release_oh) | cap;
      ack_q   <= cap;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= PTR_W'(1);
      consec      <= '0;
      wd          <= '0;
      mem_req     <= 1'b0;
      mem_wren    <= 1'b0;
      mem_addr    <= '0;
      done_q      <= '0;
      err_timeout <= 1'b0;
    end else begin
      done_q  <= '0;
      mem_req <= 1'b0;
      if (wd_expire)    err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (|pending) begin
            grant    <= win_oh;
            gidx     <= win_idx;
            mem_req  <= 1'b1;
            mem_addr <= lat_addr[win_idx];
            mem_wren <= lat_wren[win_idx];
            state    <= ST_ISSUE;
            if (win_oh[0]) begin
              if (!others)                            consec <= '0;
              else if (consec != CW'(VID_MAX_CONSEC)) consec <= consec + 1'b1;
            end else begin
              consec <= '0;
              rr_ptr <= (win_idx == PTR_W'(NUM_PORTS - 1)) ? PTR_W'(1) : win_idx + 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          wd    <= '0;
          state <= ST_BURST;
        end
        ST_BURST: begin
          if (burst_end) begin
            done_q   <= grant;
            grant    <= '0;
            mem_wren <= 1'b0;
            state    <= ST_GAP;
          end else if (wd_expire) begin
            grant    <= '0;
            mem_wren <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xg_mem_arbiter.sv
// Directed bench for xg_mem_arbiter: small requester and controller models
// driven at the falling edge, hand-computed expectations checked there.
module tb_xg_mem_arbiter;
  import xg_mem_pkg::*;

  localparam int NP = 3;
  localparam int AW = 17;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic [NP-1:0] grant;
  logic          err_timeout, err_clr;
  logic          mem_req, mem_wren;
  logic [AW-1:0] mem_addr;
  logic [15:0]   to_mem;
  logic          mem_ready;
  logic [1:0]    mem_offset;
  logic [15:0]   from_mem;

  always #5 clk_sys = ~clk_sys;

  xg_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

  xg_mem_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .VID_MAX_CONSEC(4), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .req_bus     (bus),
    .grant       (grant),
    .err_timeout (err_timeout),
    .err_clr     (err_clr),
    .mem_req     (mem_req),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .to_mem      (to_mem),
    .mem_ready   (mem_ready),
    .mem_offset  (mem_offset),
    .from_mem    (from_mem)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ctl_cnt = -1;
  bit          ctl_on = 1'b1;
  logic [NP-1:0] auto_mask = '0;
  int          gq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh2i(input logic [NP-1:0] oh);
    oh2i = -1;
    for (int i = 0; i < NP; i++) if (oh[i]) oh2i = i;
  endfunction

  // One falling edge: requesters drop req on ack (and re-raise on done when
  // running continuously), the controller returns 4 beats after mem_req.
  task automatic step();
    @(negedge clk_sys);
    for (int k = 0; k < NP; k++) begin
      if (bus.port_ack[k]) bus.port_req[k] = 1'b0;
      if (bus.port_done[k] && auto_mask[k]) bus.port_req[k] = 1'b1;
    end
    if (mem_req) gq.push_back(oh2i(grant));
    if (ctl_cnt >= 0 && ctl_cnt < 4) begin
      mem_ready  = 1'b1;
      mem_offset = 2'(ctl_cnt);
      from_mem   = 16'hA000 + 16'(ctl_cnt);
      ctl_cnt++;
    end else begin
      mem_ready  = 1'b0;
      mem_offset = 2'd0;
      ctl_cnt    = -1;
    end
    if (mem_req && ctl_on) ctl_cnt = 0;
    for (int k = 0; k < NP; k++)
      bus.port_wdata[k*16 +: 16] = 16'hD000 + 16'(k * 256) + 16'(int'(mem_offset) * 17);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.port_req  = '0;
    ctl_cnt       = -1;
    mem_ready     = 1'b0;
    mem_offset    = 2'd0;
    auto_mask     = '0;
    ctl_on        = 1'b1;
    err_clr       = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    gq.delete();
  endtask

  task automatic wait_done(input string tag, input int port);
    int seen;
    seen = 0;
    for (int s = 0; s < 20 && seen == 0; s++) begin
      step();
      if (bus.port_done[port]) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    logic [15:0] exp_wd [4];
    int          exp3 [10];
    int          exp4 [4];
    int          beats, stray, last_s, done_s, dn, guard;

    exp_wd = '{16'hD000, 16'hD011, 16'hD022, 16'hD033};
    exp3   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    exp4   = '{1, 2, 1, 2};
    bus.port_wren  = '0;
    bus.port_addr  = '0;
    bus.port_wdata = '0;
    from_mem       = 16'd0;

    // Reset state
    do_reset();
    check("rst_grant", grant, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ack_done", {bus.port_ack, bus.port_done}, 0);
    check("rst_err", err_timeout, 0);

    // Single port-1 read at 0x00104
    bus.port_req[1]          = 1'b1;
    bus.port_wren[1]         = 1'b0;
    bus.port_addr[AW +: AW]  = 17'h00104;
    step();
    check("s1_ack", bus.port_ack, 3'b010);
    check("s1_req_early", mem_req, 0);
    step();
    check("s1_mem_req", mem_req, 1);
    check("s1_mem_addr", mem_addr, 17'h00104);
    check("s1_mem_wren", mem_wren, 0);
    check("s1_grant", grant, 3'b010);
    beats = 0; stray = 0; last_s = -10; done_s = -1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (bus.port_ready[1]) begin
        beats++;
        if (bus.port_offset == 2'd3) begin
          last_s = s;
          check("s1_rdata_last", bus.port_rdata, 16'hA003);
        end
      end
      if ((bus.port_ready & 3'b101) != 0) stray++;
      if (bus.port_done[1] && done_s < 0) done_s = s;
    end
    check("s1_beats", beats, 4);
    check("s1_stray_ready", stray, 0);
    check("s1_done_lat", done_s - last_s, 1);
    check("s1_grant_free", grant, 0);

    // Port-0 write at 0x00200
    bus.port_req[0]       = 1'b1;
    bus.port_wren[0]      = 1'b1;
    bus.port_addr[0 +: AW] = 17'h00200;
    step();
    check("s2_ack", bus.port_ack, 3'b001);
    check("s2_ready_pre", bus.port_ready, 0);
    check("s2_to_mem_idle", to_mem, 0);
    step();
    check("s2_mem_req", mem_req, 1);
    check("s2_mem_wren", mem_wren, 1);
    check("s2_mem_addr", mem_addr, 17'h00200);
    check("s2_ready_issue", bus.port_ready, 0);
    for (int b = 0; b < 4; b++) begin
      step();
      check($sformatf("s2_ready_b%0d", b), bus.port_ready, 3'b001);
      check($sformatf("s2_wren_b%0d", b), mem_wren, 1);
      check($sformatf("s2_to_mem_b%0d", b), to_mem, exp_wd[b]);
    end
    step();
    check("s2_done", bus.port_done, 3'b001);
    check("s2_wren_end", mem_wren, 0);
    check("s2_to_mem_end", to_mem, 0);

    // Ports 0,1,2 continuous: bounded video priority
    do_reset();
    bus.port_wren = '0;
    auto_mask     = 3'b111;
    bus.port_req  = 3'b111;
    for (int s = 0; s < 400 && gq.size() < 10; s++) step();
    check("s3_count", gq.size(), 10);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      check($sformatf("s3_grant%0d", i), gq[i], exp3[i]);

    // Ports 1,2 continuous: alternation with pointer wrap
    do_reset();
    auto_mask    = 3'b110;
    bus.port_req = 3'b110;
    for (int s = 0; s < 200 && gq.size() < 4; s++) step();
    check("s4_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check($sformatf("s4_grant%0d", i), gq[i], exp4[i]);

    // Watchdog: controller never answers port 1, port 2 waits behind it
    do_reset();
    ctl_on       = 1'b0;
    bus.port_req = 3'b110;
    step();
    check("s5_ack", bus.port_ack, 3'b110);
    step();
    check("s5_grant", grant, 3'b010);
    dn = 0;
    for (int s = 1; s <= 256; s++) begin
      step();
      if (bus.port_done != 0) dn++;
      if (s == 255) begin
        check("s5_err_before", err_timeout, 0);
        err_clr = 1'b1;
      end
    end
    err_clr = 1'b0;
    check("s5_err_set_wins", err_timeout, 1);
    check("s5_grant_clr", grant, 0);
    check("s5_no_done", dn, 0);
    ctl_on = 1'b1;
    step();
    check("s5_next_req", mem_req, 1);
    check("s5_next_grant", grant, 3'b100);
    wait_done("s5_next_done", 2);
    check("s5_err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("s5_err_cleared", err_timeout, 0);

    // Reset in the middle of a write burst, at the offset-1 beat
    do_reset();
    bus.port_req[1]         = 1'b1;
    bus.port_wren[1]        = 1'b1;
    bus.port_addr[AW +: AW] = 17'h00340;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!(bus.port_ready[1] && bus.port_offset == 2'd1) && guard < 30);
    check("s6_reached_beat1", guard < 30, 1);
    rst_n = 1'b0;
    #1;
    check("s6_grant", grant, 0);
    check("s6_mem_req", mem_req, 0);
    check("s6_mem_wren", mem_wren, 0);
    check("s6_mem_addr", mem_addr, 0);
    check("s6_ready", bus.port_ready, 0);
    check("s6_to_mem", to_mem, 0);
    check("s6_ack_done", {bus.port_ack, bus.port_done}, 0);
    mem_ready    = 1'b0;
    ctl_cnt      = -1;
    bus.port_req = '0;
    @(negedge clk_sys);
    rst_n = 1'b1;
    dn = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (bus.port_done != 0) dn++;
    end
    check("s6_silent", dn, 0);
    bus.port_req[2]             = 1'b1;
    bus.port_wren[2]            = 1'b0;
    bus.port_addr[2*AW +: AW]   = 17'h00308;
    step();
    check("s6_ack2", bus.port_ack, 3'b100);
    step();
    check("s6_mem_req2", mem_req, 1);
    check("s6_mem_addr2", mem_addr, 17'h00308);
    check("s6_grant2", grant, 3'b100);
    wait_done("s6_done2", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
